// File: rtl/usb_tx_if.sv
// Packet request and line-drive bundle between a packet source and the USB transmit controller.
interface usb_tx_if;
  logic        tx_start;
  logic [1:0]  tx_type;
  logic [63:0] tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        dp_out;
  logic        dm_out;

  modport master (output tx_start, tx_type, tx_data,
                  input  tx_busy, tx_done, dp_out, dm_out);
  modport slave  (input  tx_start, tx_type, tx_data,
                  output tx_busy, tx_done, dp_out, dm_out);
endinterface

// File: rtl/usb_tx_ctrl.sv
// USB low-level packet transmitter: SYNC/PID/payload/CRC with NRZI, bit stuffing and EOP.
// Start accepted in IDLE only; line changes on bit boundaries, first SYNC bit the cycle after acceptance.
module usb_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic     clk,
  input logic     n_rst,
  usb_tx_if.slave bus
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SEND_SYNC  = 3'd1;
  localparam logic [2:0] SEND_PID   = 3'd2;
  localparam logic [2:0] SEND_CRC5  = 3'd3;
  localparam logic [2:0] SEND_DATA  = 3'd4;
  localparam logic [2:0] SEND_CRC16 = 3'd5;
  localparam logic [2:0] EOP_SE0    = 3'd6;
  localparam logic [2:0] EOP_J      = 3'd7;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [2:0]    state, nxt_state;
  logic [CW-1:0] clk_cnt;
  logic [5:0]    bit_idx, nxt_idx;
  logic [2:0]    ones;
  logic [1:0]    pkt_type;
  logic [63:0]   pkt_data;
  logic [4:0]    crc5, crc5_nxt;
  logic [15:0]   crc16, crc16_nxt;
  logic [7:0]    pid;
  logic          nxt_bit, nxt_is_field, bit_end;
  logic          dp, dm, busy, done;

  assign bus.dp_out  = dp;
  assign bus.dm_out  = dm;
  assign bus.tx_busy = busy;
  assign bus.tx_done = done;
  assign bit_end     = (clk_cnt == CNT_LAST);

  always_comb begin
    case (pkt_type)
      2'b00:   pid = 8'h96;
      2'b01:   pid = 8'h3C;
      default: pid = 8'h2D;
    endcase
  end

  // Position and value of the bit launched at the next bit boundary.
  always_comb begin
    nxt_state = state;
    nxt_idx   = bit_idx + 6'd1;
    case (state)
      SEND_SYNC:  if (bit_idx == 6'd7) begin nxt_state = SEND_PID; nxt_idx = 6'd0; end
      SEND_PID:   if (bit_idx == 6'd7) begin
                    nxt_idx = 6'd0;
                    case (pkt_type)
                      2'b00:   nxt_state = SEND_CRC5;
                      2'b01:   nxt_state = SEND_DATA;
                      default: nxt_state = EOP_SE0;
                    endcase
                  end
      SEND_CRC5:  if (bit_idx == 6'd4)  begin nxt_state = EOP_SE0;    nxt_idx = 6'd0; end
      SEND_DATA:  if (bit_idx == 6'd63) begin nxt_state = SEND_CRC16; nxt_idx = 6'd0; end
      SEND_CRC16: if (bit_idx == 6'd15) begin nxt_state = EOP_SE0;    nxt_idx = 6'd0; end
      EOP_SE0:    if (bit_idx == 6'd1)  begin nxt_state = EOP_J;      nxt_idx = 6'd0; end
      default:    ;
    endcase

    nxt_is_field = 1'b1;
    case (nxt_state)
      SEND_SYNC:  nxt_bit = (nxt_idx == 6'd7);
      SEND_PID:   nxt_bit = pid[nxt_idx[2:0]];
      SEND_CRC5:  nxt_bit = ~crc5[3'd4 - nxt_idx[2:0]];
      SEND_DATA:  nxt_bit = pkt_data[nxt_idx];
      SEND_CRC16: nxt_bit = ~crc16[4'd15 - nxt_idx[3:0]];
      default:    begin nxt_bit = 1'b1; nxt_is_field = 1'b0; end
    endcase

    crc5_nxt  = {crc5[3:0], 1'b0} ^ ((crc5[4] ^ nxt_bit) ? 5'h05 : 5'h00);
    crc16_nxt = {crc16[14:0], 1'b0} ^ ((crc16[15] ^ nxt_bit) ? 16'h8005 : 16'h0000);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      ones     <= '0;
      pkt_type <= '0;
      pkt_data <= '0;
      crc5     <= 5'h1F;
      crc16    <= 16'hFFFF;
      dp       <= 1'b1;
      dm       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.tx_start && bus.tx_type != 2'b11) begin
          // First SYNC bit is a 0, so the line toggles J->K straight away.
          state    <= SEND_SYNC;
          pkt_type <= bus.tx_type;
          pkt_data <= bus.tx_data;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          ones     <= '0;
          crc5     <= 5'h1F;
          crc16    <= 16'hFFFF;
          dp       <= 1'b0;
          dm       <= 1'b1;
          busy     <= 1'b1;
        end
      end else if (!bit_end) begin
        clk_cnt <= clk_cnt + 1'b1;
        if (state == EOP_J && clk_cnt == CNT_PRE)
          done <= 1'b1;
      end else begin
        clk_cnt <= '0;
        if (state == EOP_J) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (ones == 3'd6) begin
          // Stuff bit: field position holds, line toggles for one bit time.
          dp   <= ~dp;
          dm   <= ~dm;
          ones <= 3'd0;
        end else begin
          state   <= nxt_state;
          bit_idx <= nxt_idx;
          if (nxt_is_field) begin
            if (!nxt_bit) begin
              dp <= ~dp;
              dm <= ~dm;
            end
            ones <= nxt_bit ? ones + 3'd1 : 3'd0;
            if (nxt_state == SEND_PID)  crc5  <= crc5_nxt;
            if (nxt_state == SEND_DATA) crc16 <= crc16_nxt;
          end else if (nxt_state == EOP_SE0) begin
            dp   <= 1'b0;
            dm   <= 1'b0;
            ones <= 3'd0;
          end else begin
            dp <= 1'b1;
            dm <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Bench for usb_tx_ctrl: packet-level model expands each request into line symbols, compared every cycle.
module tb_usb_tx_ctrl;
  localparam int CPB = 8;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  usb_tx_if bus();

  usb_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] line; logic busy; logic done; } exp_t;
  exp_t       exp_q[$];
  logic [1:0] cap_q[$];
  bit         raw_q[$];
  logic [1:0] sym_q[$];
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  function automatic logic [15:0] crc_calc(input int w, input logic [15:0] poly,
                                           input logic [63:0] msg, input int n);
    logic [15:0] r;
    logic [31:0] m;
    logic top;
    m = (32'd1 << w) - 32'd1;
    r = m[15:0];
    for (int i = 0; i < n; i++) begin
      top = r[w-1] ^ msg[i];
      r = (r << 1) & m[15:0];
      if (top) r = r ^ poly;
    end
    return r;
  endfunction

  // Raw field bits, then stuffing and NRZI into line symbols, then EOP.
  function automatic void build(input logic [1:0] t, input logic [63:0] d);
    logic [7:0]  pid;
    logic [15:0] c;
    logic [1:0]  line;
    int ones;
    raw_q.delete();
    sym_q.delete();
    for (int i = 0; i < 8; i++) raw_q.push_back(i == 7);
    pid = (t == 2'b00) ? 8'h96 : (t == 2'b01) ? 8'h3C : 8'h2D;
    for (int i = 0; i < 8; i++) raw_q.push_back(pid[i]);
    if (t == 2'b00) begin
      c = crc_calc(5, 16'h0005, {56'd0, pid}, 8);
      for (int i = 4; i >= 0; i--) raw_q.push_back(~c[i]);
    end
    if (t == 2'b01) begin
      for (int i = 0; i < 64; i++) raw_q.push_back(d[i]);
      c = crc_calc(16, 16'h8005, d, 64);
      for (int i = 15; i >= 0; i--) raw_q.push_back(~c[i]);
    end
    line = J;
    ones = 0;
    foreach (raw_q[i]) begin
      if (!raw_q[i]) line = ~line;
      sym_q.push_back(line);
      ones = raw_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line = ~line;
        sym_q.push_back(line);
        ones = 0;
      end
    end
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    sym_q.push_back(J);
  endfunction

  task automatic push_exp();
    exp_q.push_back({J, 1'b0, 1'b0});
    foreach (sym_q[i])
      for (int c = 0; c < CPB; c++)
        exp_q.push_back({sym_q[i], 1'b1, (i == sym_q.size() - 1) && (c == CPB - 1)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = {J, 1'b0, 1'b0};
      check("line_busy_done", {bus.dp_out, bus.dm_out, bus.tx_busy, bus.tx_done}, e);
      if (bus.tx_busy) cap_q.push_back({bus.dp_out, bus.dm_out});
    end
  end

  // Returns at the start of the tx_done cycle; poke re-pulses tx_start at that cycle number.
  task automatic send_pkt(input logic [1:0] t, input logic [63:0] d, input int poke);
    int len;
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_type  = t;
    bus.tx_data  = d;
    build(t, d);
    push_exp();
    cap_q.delete();
    len = sym_q.size() * CPB;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    bus.tx_type  = ~t;
    bus.tx_data  = ~d;
    for (int k = 2; k <= len; k++) begin
      @(posedge clk);
      if (k == poke) begin #1 bus.tx_start = 1'b1; end
      else if (k == poke + 1) begin #1 bus.tx_start = 1'b0; end
    end
  endtask

  task automatic post_hs();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[29:0], sym_q[i]};
    check("model_hs_syms", v, 32'h6665_6A59);
    check("model_hs_len", sym_q.size(), 19);
    check("hs_busy_cycles", cap_q.size(), 152);
  endtask

  task automatic post_token();
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 5; i++) c = {c[3:0], raw_q[16 + i]};
    check("model_crc5_bits", c, 5'b01110);
    check("token_busy_cycles", cap_q.size(), 192);
  endtask

  task automatic post_data(input logic [63:0] d);
    logic [1:0]  prev, s;
    logic [63:0] got;
    logic [15:0] crc_got, crc_exp;
    bit dec[$];
    bit b;
    int ones, stuffs;
    prev = J; ones = 0; stuffs = 0;
    for (int i = CPB / 2; i < cap_q.size(); i += CPB) begin
      s = cap_q[i];
      if (s == SE0) break;
      b = (s == prev);
      prev = s;
      if (ones == 6) begin
        stuffs++;
        ones = 0;
      end else begin
        dec.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
    if (dec.size() < 96) begin
      check("data_decoded_len", dec.size(), 96);
    end else begin
      for (int i = 0; i < 64; i++) got[i] = dec[16 + i];
      for (int i = 0; i < 16; i++) begin
        crc_got[15 - i] = dec[80 + i];
        crc_exp[15 - i] = raw_q[80 + i];
      end
      check("data_payload", got, d);
      check("data_crc16", crc_got, crc_exp);
    end
    check("data_stuff_count", stuffs, sym_q.size() - raw_q.size() - 3);
    check("data_frame_bits", cap_q.size() / CPB, 99 + stuffs);
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_type  = 2'b00;
    bus.tx_data  = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_state", {bus.dp_out, bus.dm_out, bus.tx_busy, bus.tx_done}, 4'b1000);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    send_pkt(2'b10, 64'd0, 0);
    @(negedge clk); #1;
    post_hs();

    send_pkt(2'b00, 64'd0, 0);
    @(negedge clk); #1;
    post_token();

    send_pkt(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 300);
    @(negedge clk); #1;
    post_data(64'hFFFF_FFFF_FFFF_FFFF);
    check("model_allones_stuffs_min", (sym_q.size() - raw_q.size() - 3) >= 10, 1'b1);

    send_pkt(2'b01, 64'h0123_4567_89AB_CDEF, 0);
    @(negedge clk); #1;
    post_data(64'h0123_4567_89AB_CDEF);

    // Reserved type: must be ignored.
    cap_q.delete();
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_type  = 2'b11;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("reserved_busy_cycles", cap_q.size(), 0);

    // Back-to-back: new start in the cycle right after tx_done.
    send_pkt(2'b10, 64'd0, 0);
    send_pkt(2'b00, 64'd0, 0);
    @(negedge clk); #1;
    post_token();

    // Reset during SEND_PID.
    @(posedge clk); #1;
    bus.tx_start = 1'b1;
    bus.tx_type  = 2'b10;
    build(2'b10, 64'd0);
    push_exp();
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    repeat (90) @(posedge clk);
    #2 n_rst = 1'b0;
    exp_q.delete();
    #1 check("reset_mid_pid", {bus.dp_out, bus.dm_out, bus.tx_busy, bus.tx_done}, 4'b1000);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (4) @(posedge clk);
    send_pkt(2'b10, 64'd0, 0);
    @(negedge clk); #1;
    post_hs();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/usb_tx_ctrl.md
USB_TX_CTRL -- requirements
Module: usb_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: number of clk cycles per line bit time (legal values 4 or more).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port tx_start, input, 1 bit: request to send one packet; sampled only in IDLE.
REQ-005 SHALL have port tx_type, input, 2 bits: 00 token, 01 data, 10 handshake, 11 reserved.
REQ-006 SHALL have port tx_data, input, 64 bits: data packet payload.
REQ-007 SHALL have port tx_busy, output, 1 bit: high while a packet is in progress.
REQ-008 SHALL have port tx_done, output, 1 bit: one-cycle pulse at packet completion.
REQ-009 SHALL have port dp_out, output, 1 bit: D+ line drive.
REQ-010 SHALL have port dm_out, output, 1 bit: D- line drive.

Function
REQ-011 SHALL use the following FSM states: IDLE, SEND_SYNC, SEND_PID, SEND_CRC5, SEND_DATA, SEND_CRC16, EOP_SE0, EOP_J.
REQ-012 SHALL accept a start in IDLE only when tx_start=1 and tx_type≠11; at acceptance it latches tx_type and tx_data and moves to SEND_SYNC.
REQ-013 SHALL ignore tx_start in any non-IDLE state, and ignore tx_type=11 (stays IDLE, no line activity).
REQ-014 SHALL hold each line bit for exactly CLKS_PER_BIT cycles using a bit-timing counter that restarts at acceptance; the first SYNC bit drives the line in the cycle after acceptance.
REQ-015 SHALL send field sequences per type:
- token: SYNC, PID 8'h96, CRC5.
- data: SYNC, PID 8'h3C, 64 data bits, CRC16.
- handshake: SYNC, PID 8'h2D.
Every packet then ends with EOP.
REQ-016 SHALL send SYNC as 8'h80, and SYNC, PID and data LSB-first; tx_data[0] is the first data bit.
REQ-017 SHALL compute CRC5 serially over the 8 PID bits: polynomial x^5+x^2+1, seed 5'h1F; it sends the inverted remainder, MSB first.
REQ-018 SHALL compute CRC16 serially over the 64 data bits: polynomial x^16+x^15+x^2+1, seed 16'hFFFF; it sends the inverted remainder, MSB first.
REQ-019 SHALL NRZI-encode all bits from SYNC through the last CRC bit: 0 toggles the line, 1 holds it.
REQ-020 SHALL represent line states as J = (dp_out=1, dm_out=0) and K = (0,1); the line is J in IDLE before SYNC.
REQ-021 SHALL bit-stuff:
- after six consecutive 1 data bits, insert one 0 (a line toggle) lasting one bit time;
- the field bit counter does not advance during a stuff bit;
- the ones-run counter clears on any 0, including stuffed bits, and at acceptance.
REQ-022 SHALL insert the stuff bit before EOP when the sixth consecutive 1 is the final CRC bit (or final PID bit for handshake).
REQ-023 SHALL move to the next field after the last bit time of the current field; no gap bits are inserted between fields.
REQ-024 SHALL drive EOP_SE0 as dp_out=dm_out=0 for 2 bit times, then EOP_J as J for 1 bit time.
REQ-025 SHALL assert tx_busy from the cycle after acceptance through the tx_done cycle inclusive.
REQ-026 SHALL pulse tx_done in the last clk cycle of EOP_J, with return to IDLE on the next edge.
REQ-027 SHALL accept a new tx_start in IDLE in the cycle immediately after tx_done.
REQ-028 SHALL have no output glitches: dp_out and dm_out are registered.

Reset
REQ-029 SHALL, on n_rst=0 at any time (including mid-packet), immediately force:
- state IDLE;
- dp_out=1, dm_out=0;
- tx_busy=0, tx_done=0;
- all counters and CRC registers cleared or seeded;
- no partial packet resumes after reset release.

Verification
REQ-030 Handshake scenario: tx_type=10, tx_start pulse.
- Line shows SYNC KJKJKJKK.
- PID 8'h2D NRZI-encoded, no stuff bits.
- SE0 for 16 clk, J for 8 clk.
- tx_busy high for 152 clk.
- tx_done pulses once at clk 152 after acceptance.
REQ-031 Token scenario: tx_type=00 -> SYNC, PID 8'h96, inverted CRC5 of 8'h96 per REQ-017 MSB-first, EOP; total of 24 bit times plus any stuff bits (per golden model).
REQ-032 Data scenario, stuffing: tx_data=64'hFFFF_FFFF_FFFF_FFFF.
- A stuff 0 is inserted after every 6th consecutive 1.
- The decoded, unstuffed payload equals the input.
- The CRC16 field matches the golden model.
- The frame is longer than the unstuffed 99 bit times by exactly the stuff count.
REQ-033 Busy/reserved scenario:
- tx_start re-asserted during SEND_DATA -> no effect, one tx_done only.
- tx_type=11 with tx_start in IDLE -> tx_busy stays 0, line stays J.
REQ-034 Reset scenario: n_rst low during SEND_PID -> same cycle dp_out=1, dm_out=0, tx_busy=0; after release, a new handshake completes normally.
